// File: rtl/regbus_pkg.sv
// Shared types and constants for the two-master peripheral register bus arbiter.
package regbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic M_I2C   = 1'b0;
  localparam logic M_LOCAL = 1'b1;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/regbus_rr_pick.sv
// Combinational two-way pick: round-robin on ties against the last owner, or
// fixed priority to master 0 when PRIO_FIXED is non-zero.
module regbus_rr_pick
  import regbus_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic gnt_id,
  output logic grant,
  output logic pick_id
);

  always_comb begin
    grant   = req0 | req1;
    pick_id = M_I2C;
    if (req0 && req1) begin
      pick_id = (PRIO_FIXED != 0) ? M_I2C : ~gnt_id;
    end else if (req1) begin
      pick_id = M_LOCAL;
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Two-master arbiter for the single-port register bus: one transaction at a time,
// one-cycle bus strobe, programmable read latency, one-cycle ack to the owner.
//
// Handshake: a master raises req with rw/addr/wdata valid and holds req until its
// ack pulses; fields are sampled only in the IDLE cycle that grants it, ack is a
// single-cycle completion, and req must drop the cycle after ack unless a new
// transaction is being issued.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LATENCY = 1,
  parameter int PRIO_FIXED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          bus_en,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy,
  output logic          gnt_id,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_e        state, state_n;
  logic          owner_q;
  logic          rw_q;
  logic [1:0]    cnt_q;
  logic          gnt_id_q;
  logic          grant, pick_id;
  logic          do_grant, do_capture, load_cnt, dec_cnt;
  logic          sel_rw;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  regbus_rr_pick #(.PRIO_FIXED(PRIO_FIXED)) u_pick (
    .req0    (req0),
    .req1    (req1),
    .gnt_id  (gnt_id_q),
    .grant   (grant),
    .pick_id (pick_id)
  );

  assign sel_rw    = pick_id ? rw1    : rw0;
  assign sel_addr  = pick_id ? addr1  : addr0;
  assign sel_wdata = pick_id ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          do_grant = 1'b1;
          state_n  = BUS;
        end
      end
      BUS: begin
        if (!rw_q) begin
          state_n = ACK;
        end else if (LAT == 2'd0) begin
          do_capture = 1'b1;
          state_n    = ACK;
        end else begin
          load_cnt = 1'b1;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        // Count 1 is the cycle bus_rdata is valid (BUS + RD_LATENCY).
        if (cnt_q == 2'd1) begin
          do_capture = 1'b1;
          state_n    = ACK;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= M_I2C;
      rw_q      <= 1'b0;
      cnt_q     <= 2'd0;
      gnt_id_q  <= M_LOCAL;
      bus_en    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      bus_en <= do_grant;
      if (do_grant) begin
        owner_q   <= pick_id;
        rw_q      <= sel_rw;
        bus_we    <= ~sel_rw;
        bus_addr  <= sel_addr;
        bus_wdata <= sel_wdata;
      end
      if (load_cnt)     cnt_q <= LAT;
      else if (dec_cnt) cnt_q <= cnt_q - 2'd1;
      if (do_capture) begin
        if (owner_q == M_LOCAL) rdata1 <= bus_rdata;
        else                    rdata0 <= bus_rdata;
      end
      if (state == ACK) gnt_id_q <= owner_q;
    end
  end

  assign ack0      = (state == ACK) && (owner_q == M_I2C);
  assign ack1      = (state == ACK) && (owner_q == M_LOCAL);
  assign busy      = (state != IDLE);
  assign gnt_id    = gnt_id_q;
  assign dbg_state = state;

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
- Two-master arbiter for the single-port peripheral register bus: scratch memory, GPIO/PWM control, status reads.
- Master 0 is the I2C slave application interface; master 1 is an on-chip requester, e.g. the dice logic posting its last roll.
- Serialises one transaction at a time, sequences bus_en/bus_we, waits the read latency, returns data and a one-cycle ack to the owner.
- Sits between the I2C slave/local logic and the register decode.

Parameters:
- AW, 8, register address width.
- DW, 8, data width.
- RD_LATENCY, 1, cycles from bus_en cycle to bus_rdata valid; legal 0..3.
- PRIO_FIXED, 0: 0 = round-robin; 1 = master 0 always wins ties.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req0  input  1  master 0 request, held until ack0
- rw0  input  1  master 0 direction: 1 = read, 0 = write
- addr0  input  AW  master 0 address
- wdata0  input  DW  master 0 write data
- ack0  output  1  one-cycle completion pulse to master 0
- rdata0  output  DW  master 0 read data, valid from ack0, held until its next read ack
- req1/rw1/addr1/wdata1/ack1/rdata1  same as master 0, for master 1
- bus_en  output  1  one-cycle bus strobe
- bus_we  output  1  write enable; qualified by bus_en
- bus_addr  output  AW  bus address
- bus_wdata  output  DW  bus write data
- bus_rdata  input  DW  read data, valid RD_LATENCY cycles after the bus_en cycle
- busy  output  1  high in any state other than IDLE
- gnt_id  output  1  current/last owner index

Behaviour:
- Reset (rst high at a clk edge) values:
  - state = IDLE.
  - bus_en, bus_we, ack0, ack1, busy = 0.
  - bus_addr, bus_wdata, rdata0, rdata1 = 0.
  - gnt_id = 1, so the first tie goes to master 0.
- Reset mid-transaction aborts immediately and no ack is issued. A write whose bus_en has already fired stays committed.
- States:
  - IDLE: sample req0/req1. If neither is asserted, stay. If both are asserted:
    - PRIO_FIXED = 1: grant 0.
    - PRIO_FIXED = 0: grant the master that is not gnt_id.
  - On grant: latch owner, rw, addr, wdata into internal registers; go to BUS.
  - BUS: bus_en = 1 for exactly one cycle, bus_we = !rw, bus_addr/bus_wdata from the latched values.
    - Write → ACK.
    - Read with RD_LATENCY = 0 → capture bus_rdata this cycle, then ACK.
    - Otherwise → WAIT with counter = RD_LATENCY.
  - WAIT: decrement the counter each cycle. On the cycle the counter reaches its last count (cycle BUS + RD_LATENCY), capture bus_rdata into the owner's rdata register, then → ACK.
  - ACK: pulse ack of the owner for one cycle; update gnt_id = owner; → IDLE.
- Bus outputs hold their last values when bus_en = 0.
- Latency, counted from the IDLE grant cycle N:
  - Write: bus_en at N+1, ack at N+2.
  - Read: bus_en at N+1, ack at N+2+RD_LATENCY (for RD_LATENCY ≥ 1); ack at N+2 for RD_LATENCY = 0.
- Throughput: back-to-back is allowed. A new grant can be made in the IDLE cycle right after ACK, so at most one write per 3 cycles.
- Master rules:
  - Fields are sampled only in the grant cycle; later changes are ignored.
  - req must drop in the cycle after ack unless the master is issuing a new transaction.
  - Dropping req after grant does not cancel: the transaction completes and ack still pulses.
- Requests are not registered while busy. The losing master simply keeps req high and is granted in the next IDLE. Under round-robin, alternation is guaranteed, so the worst-case wait is one full transaction.
- The non-owner's rdata never changes. Write acks leave both rdata registers unchanged.

Decomposition:
- Shared package regbus_pkg:
  - state enum IDLE/BUS/WAIT/ACK.
  - Master index constants M_I2C = 0 and M_LOCAL = 1.
  - Default AW/DW localparams.
- One sub-module, regbus_rr_pick: combinational two-way pick from req0, req1, gnt_id, PRIO_FIXED. It contains no state; the FSM, latching and read capture live in the top.

Test Plan:
- Single master-0 write, addr 0x02, data 0xA5 → bus_en at N+1 with bus_we = 1, bus_addr = 0x02, bus_wdata = 0xA5; ack0 at N+2; ack1 never pulses.
- Master-1 read, addr 0x04, RD_LATENCY = 1, model returns 0x3C → bus_en at N+1 with bus_we = 0; ack1 at N+3; rdata1 = 0x3C; rdata0 unchanged.
- Both masters request continuously from reset, round-robin, writes → grant order 0,1,0,1; each ack 3 cycles apart.
- With PRIO_FIXED = 1 → only master 0 is served while req0 stays high.
- RD_LATENCY = 0 and RD_LATENCY = 3 sweeps: master-0 read of 0x7E → ack0 at N+2 and N+5 respectively; data 0x7E captured on the correct cycle (model drives garbage elsewhere).
- Master 0 drops req one cycle after grant → transaction still completes and ack0 pulses.
- rst asserted during WAIT → next cycle busy = 0, no ack, rdata registers = 0, gnt_id = 1; a subsequent tie grants master 0.
